// File: rtl/rtc_write_ctrl.sv
// rtc_write_ctrl: writer side of the RTC multiplexed address/data bus.
// On a start request it snapshots the user clock/date or timer values,
// then writes them one register at a time (address phase, then data
// phase, each a strobe pulse followed by a gap) and finishes with a
// transfer command. Bus outputs are registered so strobes are glitch-free.

module rtc_write_ctrl #(
  parameter int unsigned T_LOW = 4,  // cycles each cs_n/wr_n low pulse lasts
  parameter int unsigned T_GAP = 4   // cycles strobes stay high between phases
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       En_clock,
  input  logic [7:0] seg_usu,
  input  logic [7:0] min_usu,
  input  logic [7:0] hora_usu,
  input  logic [7:0] dia_usu,
  input  logic [7:0] mes_usu,
  input  logic [7:0] ano_usu,
  input  logic [7:0] seg_T_usu,
  input  logic [7:0] min_T_usu,
  input  logic [7:0] hora_T_usu,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       a_d,
  output logic       cs_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic       busy,
  output logic       done
);

  localparam int unsigned T_MAX = (T_LOW > T_GAP) ? T_LOW : T_GAP;
  localparam int unsigned CNT_W = $clog2(T_MAX) + 1;

  localparam logic [CNT_W-1:0] LOW_RELOAD = CNT_W'(T_LOW - 1);
  localparam logic [CNT_W-1:0] GAP_RELOAD = CNT_W'(T_GAP - 1);

  // Last transaction index: 7 writes in clock mode, 4 in timer mode.
  localparam logic [2:0] LAST_CLOCK = 3'd6;
  localparam logic [2:0] LAST_TIMER = 3'd3;

  // Transfer command issued as the final write of each sequence.
  localparam logic [7:0] ADDR_CMD   = 8'hF0;
  localparam logic [7:0] CMD_CLOCK  = 8'hF1;
  localparam logic [7:0] CMD_TIMER  = 8'hF2;

  typedef enum logic [2:0] {
    IDLE,
    A_LOW,
    A_GAP,
    D_LOW,
    D_GAP,
    DONE
  } state_e;

  // Values captured at the accepted start; the sequence only reads these.
  typedef struct packed {
    logic       clk_mode;
    logic [7:0] seg;
    logic [7:0] min;
    logic [7:0] hora;
    logic [7:0] dia;
    logic [7:0] mes;
    logic [7:0] ano;
    logic [7:0] seg_t;
    logic [7:0] min_t;
    logic [7:0] hora_t;
  } snap_t;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [2:0]       idx_q,   idx_d;
  snap_t            snap_q,  snap_d;

  logic [7:0] ad_out_q, ad_out_d;
  logic       ad_oe_q,  ad_oe_d;
  logic       a_d_q,    a_d_d;
  logic       cs_n_q,   cs_n_d;
  logic       wr_n_q,   wr_n_d;
  logic       busy_q,   busy_d;
  logic       done_q,   done_d;

  logic       phase_end;
  logic [2:0] last_idx;
  logic [7:0] tx_addr;
  logic [7:0] tx_data;

  assign phase_end = (cnt_q == '0);
  assign last_idx  = snap_q.clk_mode ? LAST_CLOCK : LAST_TIMER;

  // Control state register: FSM state, phase counter and transaction index.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Snapshot register, loaded only when a start request is accepted.
  // NOTE: deliberately not reset; its contents are never observed on the
  // bus before being loaded, so a reset would only add fan-out on reset.
  always_ff @(posedge clk) begin
    snap_q <= snap_d;
  end

  // Next-state logic: phase sequencing and start acceptance.
  // NOTE: every signal gets a default first so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    snap_d  = snap_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          snap_d.clk_mode = En_clock;
          snap_d.seg      = seg_usu;
          snap_d.min      = min_usu;
          snap_d.hora     = hora_usu;
          snap_d.dia      = dia_usu;
          snap_d.mes      = mes_usu;
          snap_d.ano      = ano_usu;
          snap_d.seg_t    = seg_T_usu;
          snap_d.min_t    = min_T_usu;
          snap_d.hora_t   = hora_T_usu;
          idx_d           = '0;
          cnt_d           = LOW_RELOAD;
          state_d         = A_LOW;
        end
      end

      A_LOW: begin
        if (phase_end) begin
          cnt_d   = GAP_RELOAD;
          state_d = A_GAP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      A_GAP: begin
        if (phase_end) begin
          cnt_d   = LOW_RELOAD;
          state_d = D_LOW;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      D_LOW: begin
        if (phase_end) begin
          cnt_d   = GAP_RELOAD;
          state_d = D_GAP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      D_GAP: begin
        if (phase_end) begin
          if (idx_q == last_idx) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            cnt_d   = LOW_RELOAD;
            state_d = A_LOW;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Transaction table lookup for the upcoming cycle's index and mode.
  always_comb begin
    tx_addr = ADDR_CMD;
    tx_data = snap_d.clk_mode ? CMD_CLOCK : CMD_TIMER;
    if (snap_d.clk_mode) begin
      unique case (idx_d)
        3'd0:    begin tx_addr = 8'h21; tx_data = snap_d.seg;  end
        3'd1:    begin tx_addr = 8'h22; tx_data = snap_d.min;  end
        3'd2:    begin tx_addr = 8'h23; tx_data = snap_d.hora; end
        3'd3:    begin tx_addr = 8'h24; tx_data = snap_d.dia;  end
        3'd4:    begin tx_addr = 8'h25; tx_data = snap_d.mes;  end
        3'd5:    begin tx_addr = 8'h26; tx_data = snap_d.ano;  end
        default: begin tx_addr = ADDR_CMD; tx_data = CMD_CLOCK; end
      endcase
    end else begin
      unique case (idx_d)
        3'd0:    begin tx_addr = 8'h41; tx_data = snap_d.seg_t;  end
        3'd1:    begin tx_addr = 8'h42; tx_data = snap_d.min_t;  end
        3'd2:    begin tx_addr = 8'h43; tx_data = snap_d.hora_t; end
        default: begin tx_addr = ADDR_CMD; tx_data = CMD_TIMER;  end
      endcase
    end
  end

  // Bus output decode from the next state, so outputs line up with state.
  always_comb begin
    ad_out_d = 8'h00;
    ad_oe_d  = 1'b0;
    a_d_d    = 1'b0;
    cs_n_d   = 1'b1;
    wr_n_d   = 1'b1;
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);

    unique case (state_d)
      A_LOW: begin
        ad_out_d = tx_addr;
        ad_oe_d  = 1'b1;
        cs_n_d   = 1'b0;
        wr_n_d   = 1'b0;
      end
      A_GAP: begin
        ad_out_d = tx_addr;
        ad_oe_d  = 1'b1;
      end
      D_LOW: begin
        ad_out_d = tx_data;
        ad_oe_d  = 1'b1;
        a_d_d    = 1'b1;
        cs_n_d   = 1'b0;
        wr_n_d   = 1'b0;
      end
      D_GAP: begin
        ad_out_d = tx_data;
        ad_oe_d  = 1'b1;
        a_d_d    = 1'b1;
      end
      default: begin
        // IDLE and DONE keep the bus released with strobes high.
      end
    endcase
  end

  // Registered bus outputs so strobes and data never glitch at the pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      ad_out_q <= 8'h00;
      ad_oe_q  <= 1'b0;
      a_d_q    <= 1'b0;
      cs_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      ad_out_q <= ad_out_d;
      ad_oe_q  <= ad_oe_d;
      a_d_q    <= a_d_d;
      cs_n_q   <= cs_n_d;
      wr_n_q   <= wr_n_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign ad_out = ad_out_q;
  assign ad_oe  = ad_oe_q;
  assign a_d    = a_d_q;
  assign cs_n   = cs_n_q;
  assign wr_n   = wr_n_q;
  assign rd_n   = 1'b1;  // this block never reads the RTC
  assign busy   = busy_q;
  assign done   = done_q;

endmodule
